// File: rtl/ahb_apb_slave_if_p.sv
// rtl/ahb_apb_slave_if_p.sv - AHB-side slave interface of the AHB-to-APB bridge
// Optional macro AHB_SLV_RDATA_REG_EN registers hrdata; otherwise hrdata passes prdata through.
module ahb_apb_slave_if_p #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SEL     = 3,
  parameter logic [ADDR_W-1:0] SEL_BASE    = 32'h8000_0000,
  parameter int                REGION_LOG2 = 26
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               hwrite,
  input  logic               hreadyin,
  input  logic [1:0]         htrans,
  input  logic [ADDR_W-1:0]  haddr,
  input  logic [DATA_W-1:0]  hwdata,
  input  logic [DATA_W-1:0]  prdata,
  output logic               valid,
  output logic               hwrite_reg,
  output logic               hwrite_reg1,
  output logic [ADDR_W-1:0]  haddr1,
  output logic [ADDR_W-1:0]  haddr2,
  output logic [DATA_W-1:0]  hwdata1,
  output logic [DATA_W-1:0]  hwdata2,
  output logic [NUM_SEL-1:0] selx,
  output logic [DATA_W-1:0]  hrdata,
  output logic [1:0]         hresp,
  output logic               hready_err
);

  // Extra headroom bits so the region limit cannot wrap past the top of the address space.
  localparam int EXT_W = ADDR_W + 4;
  localparam logic [EXT_W-1:0] BASE_EXT  = EXT_W'(SEL_BASE);
  localparam logic [EXT_W-1:0] LIMIT_EXT = BASE_EXT + (EXT_W'(NUM_SEL) << REGION_LOG2);

  typedef enum logic [1:0] {
    S_OKAY = 2'd0,
    S_ERR1 = 2'd1,
    S_ERR2 = 2'd2
  } err_state_t;

  err_state_t        state;
  err_state_t        state_nxt;
  logic [EXT_W-1:0]  haddr_ext;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] region;
  logic              mapped;
  logic              active;

  assign haddr_ext = EXT_W'(haddr);
  assign mapped    = (haddr_ext >= BASE_EXT) && (haddr_ext < LIMIT_EXT);
  assign offset    = haddr - SEL_BASE;
  assign region    = offset >> REGION_LOG2;
  assign active    = hreadyin && htrans[1];
  assign valid     = active && mapped && (state == S_OKAY);

  always_comb begin
    selx = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      if (mapped && (region == ADDR_W'(i))) begin
        selx[i] = 1'b1;
      end
    end
  end

  // Pipeline captures regardless of htrans; downstream qualifies with valid.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr1      <= '0;
      haddr2      <= '0;
      hwdata1     <= '0;
      hwdata2     <= '0;
      hwrite_reg  <= 1'b0;
      hwrite_reg1 <= 1'b0;
    end else if (hreadyin) begin
      haddr1      <= haddr;
      haddr2      <= haddr1;
      hwdata1     <= hwdata;
      hwdata2     <= hwdata1;
      hwrite_reg  <= hwrite;
      hwrite_reg1 <= hwrite_reg;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= S_OKAY;
    end else begin
      state <= state_nxt;
    end
  end

  // Two-cycle ERROR response; transfers seen while it runs are dropped.
  always_comb begin
    state_nxt  = state;
    hresp      = 2'b00;
    hready_err = 1'b1;
    case (state)
      S_OKAY: begin
        if (active && !mapped) begin
          state_nxt = S_ERR1;
        end
      end
      S_ERR1: begin
        hresp      = 2'b01;
        hready_err = 1'b0;
        state_nxt  = S_ERR2;
      end
      S_ERR2: begin
        hresp     = 2'b01;
        state_nxt = S_OKAY;
      end
      default: state_nxt = S_OKAY;
    endcase
  end

`ifdef AHB_SLV_RDATA_REG_EN
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hrdata <= '0;
    end else begin
      hrdata <= prdata;
    end
  end
`else
  assign hrdata = prdata;
`endif

endmodule

// File: tb/tb_ahb_apb_slave_if_p.sv
// tb/tb_ahb_apb_slave_if_p.sv - self-checking bench for ahb_apb_slave_if_p
module tb_ahb_apb_slave_if_p;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NS   = 3;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          RL2  = 26;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic          hwrite;
  logic          hreadyin;
  logic [1:0]    htrans;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] prdata;
  logic          valid;
  logic          hwrite_reg;
  logic          hwrite_reg1;
  logic [AW-1:0] haddr1;
  logic [AW-1:0] haddr2;
  logic [DW-1:0] hwdata1;
  logic [DW-1:0] hwdata2;
  logic [NS-1:0] selx;
  logic [DW-1:0] hrdata;
  logic [1:0]    hresp;
  logic          hready_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_a1, m_a2, m_d1, m_d2, m_rd;
  logic        m_w1, m_w2;
  int          m_err_left;

  ahb_apb_slave_if_p #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SEL(NS), .SEL_BASE(BASE), .REGION_LOG2(RL2)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hreadyin(hreadyin),
    .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .prdata(prdata),
    .valid(valid), .hwrite_reg(hwrite_reg), .hwrite_reg1(hwrite_reg1),
    .haddr1(haddr1), .haddr2(haddr2), .hwdata1(hwdata1), .hwdata2(hwdata2),
    .selx(selx), .hrdata(hrdata), .hresp(hresp), .hready_err(hready_err)
  );

  always #5 hclk = ~hclk;

  function automatic logic f_mapped(input logic [31:0] a);
    longint unsigned lo, hi, x;
    lo = 64'h8000_0000;
    hi = lo + 64'd3 * (64'd1 << RL2);
    x  = {32'd0, a};
    return (x >= lo) && (x < hi);
  endfunction

  function automatic logic [2:0] f_selx(input logic [31:0] a);
    longint unsigned idx;
    if (!f_mapped(a)) return 3'b000;
    idx = ({32'd0, a} - 64'h8000_0000) / (64'd1 << RL2);
    return 3'(1 << idx);
  endfunction

  function automatic logic f_valid();
    return hreadyin && htrans[1] && f_mapped(haddr) && (m_err_left == 0);
  endfunction

  function automatic logic [31:0] f_hrdata();
`ifdef AHB_SLV_RDATA_REG_EN
    return m_rd;
`else
    return prdata;
`endif
  endfunction

  task automatic model_reset();
    m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0; m_rd = '0;
    m_w1 = 1'b0; m_w2 = 1'b0; m_err_left = 0;
  endtask

  task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic rdy);
    htrans = tr; haddr = a; hwdata = d; hwrite = w; hreadyin = rdy;
    #1;
  endtask

  // Advance one clock, updating the reference model from the inputs held across the edge.
  task automatic tick();
    logic [31:0] n_a1, n_a2, n_d1, n_d2;
    logic n_w1, n_w2, act;
    n_a1 = m_a1; n_a2 = m_a2; n_d1 = m_d1; n_d2 = m_d2; n_w1 = m_w1; n_w2 = m_w2;
    act = hreadyin && htrans[1];
    if (hreadyin) begin
      n_a1 = haddr; n_a2 = m_a1; n_d1 = hwdata; n_d2 = m_d1; n_w1 = hwrite; n_w2 = m_w1;
    end
    @(posedge hclk);
    #1;
    m_a1 = n_a1; m_a2 = n_a2; m_d1 = n_d1; m_d2 = n_d2; m_w1 = n_w1; m_w2 = n_w2;
    m_rd = prdata;
    if (m_err_left > 0) m_err_left = m_err_left - 1;
    else if (act && !f_mapped(haddr)) m_err_left = 2;
  endtask

  task automatic test_reset();
    hresetn = 1'b0; prdata = 32'h1234_5678;
    drive(2'b10, 32'h8000_0004, 32'h55, 1'b1, 1'b1);
    repeat (2) @(posedge hclk);
    #1;
    total++; if (haddr1 !== 0 || haddr2 !== 0) begin bad++; $display("FAIL reset_addr got %h %h want 0", haddr1, haddr2); end
    total++; if (hwdata1 !== 0 || hwdata2 !== 0) begin bad++; $display("FAIL reset_data got %h %h want 0", hwdata1, hwdata2); end
    total++; if (hwrite_reg !== 0 || hwrite_reg1 !== 0) begin bad++; $display("FAIL reset_wr got %b %b want 0", hwrite_reg, hwrite_reg1); end
    total++; if (hresp !== 2'b00 || hready_err !== 1'b1) begin bad++; $display("FAIL reset_resp got %b %b want 00 1", hresp, hready_err); end
    model_reset();
    total++; if (hrdata !== f_hrdata()) begin bad++; $display("FAIL reset_hrdata got %h want %h", hrdata, f_hrdata()); end
    hresetn = 1'b1;
  endtask

  task automatic test_write_pipeline();
    drive(2'b10, 32'h8000_0002, 32'd28, 1'b1, 1'b1);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL wr_valid got %b want 1", valid); end
    total++; if (selx !== 3'b001) begin bad++; $display("FAIL wr_selx got %b want 001", selx); end
    tick();
    drive(2'b00, 32'h8000_0040, 32'd0, 1'b0, 1'b1);
    total++; if (haddr1 !== 32'h8000_0002 || hwdata1 !== 32'd28) begin bad++; $display("FAIL wr_stage1 got %h %0d want 80000002 28", haddr1, hwdata1); end
    tick();
    total++; if (haddr2 !== 32'h8000_0002 || hwdata2 !== 32'd28 || hwrite_reg1 !== 1'b1)
      begin bad++; $display("FAIL wr_stage2 got %h %0d %b want 80000002 28 1", haddr2, hwdata2, hwrite_reg1); end
  endtask

  task automatic test_back_to_back();
    drive(2'b11, 32'h8000_0003, 32'd73, 1'b1, 1'b1);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL b2b_valid0 got %b want 1", valid); end
    tick();
    drive(2'b11, 32'h8000_0004, 32'd89, 1'b1, 1'b1);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL b2b_valid1 got %b want 1", valid); end
    tick();
    drive(2'b00, 32'h8000_0005, 32'd0, 1'b1, 1'b1);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_valid2 got %b want 0", valid); end
    total++; if (haddr2 !== 32'h8000_0003 || hwdata2 !== 32'd73) begin bad++; $display("FAIL b2b_a2_first got %h %0d want 80000003 73", haddr2, hwdata2); end
    tick();
    total++; if (haddr2 !== 32'h8000_0004 || hwdata2 !== 32'd89) begin bad++; $display("FAIL b2b_a2_second got %h %0d want 80000004 89", haddr2, hwdata2); end
  endtask

  task automatic test_hreadyin_hold();
    logic [31:0] a1, a2, d1, d2;
    drive(2'b10, 32'h8000_0010, 32'd11, 1'b1, 1'b1);
    tick();
    a1 = m_a1; a2 = m_a2; d1 = m_d1; d2 = m_d2;
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 32'h8000_0100 + i, 32'd500 + i, 1'b0, 1'b0);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL hold_valid[%0d] got %b want 0", i, valid); end
      tick();
      total++;
      if (haddr1 !== a1 || haddr2 !== a2 || hwdata1 !== d1 || hwdata2 !== d2) begin
        bad++; $display("FAIL hold_regs[%0d] got %h %h %h %h want %h %h %h %h", i, haddr1, haddr2, hwdata1, hwdata2, a1, a2, d1, d2);
      end
    end
    drive(2'b00, 32'h8000_0020, 32'd0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_region_decode();
    logic [31:0] addrs [4];
    logic [2:0]  sels  [4];
    addrs[0] = 32'h8400_0000; sels[0] = 3'b010;
    addrs[1] = 32'h8800_0010; sels[1] = 3'b100;
    addrs[2] = 32'h8BFF_FFFF; sels[2] = 3'b100;
    addrs[3] = 32'h7FFF_FFFF; sels[3] = 3'b000;
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, addrs[i], 32'd0, 1'b0, 1'b1);
      total++; if (selx !== sels[i]) begin bad++; $display("FAIL decode[%0d] addr %h got %b want %b", i, addrs[i], selx, sels[i]); end
    end
    drive(2'b10, 32'h8C00_0000, 32'd0, 1'b1, 1'b1);
    total++; if (selx !== 3'b000 || valid !== 1'b0 || hresp !== 2'b00)
      begin bad++; $display("FAIL err_entry got %b %b %b want 000 0 00", selx, valid, hresp); end
    tick();
    drive(2'b10, 32'h8000_0000, 32'd1, 1'b1, 1'b1);
    total++; if (hresp !== 2'b01 || hready_err !== 1'b0 || valid !== 1'b0)
      begin bad++; $display("FAIL err1 got %b %b %b want 01 0 0", hresp, hready_err, valid); end
    tick();
    drive(2'b10, 32'h9000_0000, 32'd2, 1'b1, 1'b1);
    total++; if (hresp !== 2'b01 || hready_err !== 1'b1 || valid !== 1'b0)
      begin bad++; $display("FAIL err2 got %b %b %b want 01 1 0", hresp, hready_err, valid); end
    tick();
    drive(2'b00, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    total++; if (hresp !== 2'b00 || hready_err !== 1'b1) begin bad++; $display("FAIL err_done got %b %b want 00 1", hresp, hready_err); end
    tick();
    total++; if (hresp !== 2'b00) begin bad++; $display("FAIL err_not_queued got %b want 00", hresp); end
  endtask

  task automatic test_read();
    prdata = 32'd73;
    drive(2'b10, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
`ifndef AHB_SLV_RDATA_REG_EN
    total++; if (hrdata !== 32'd73) begin bad++; $display("FAIL read_comb got %0d want 73", hrdata); end
`endif
    tick();
    prdata = 32'd99;
    #1;
    total++; if (hrdata !== f_hrdata()) begin bad++; $display("FAIL read_next got %0d want %0d", hrdata, f_hrdata()); end
`ifdef AHB_SLV_RDATA_REG_EN
    total++; if (hrdata !== 32'd73) begin bad++; $display("FAIL read_reg got %0d want 73", hrdata); end
`endif
  endtask

  task automatic test_reset_mid_error();
    drive(2'b10, 32'h8C00_0000, 32'hABCD, 1'b1, 1'b1);
    tick();
    total++; if (hresp !== 2'b01 || hready_err !== 1'b0) begin bad++; $display("FAIL rst_pre got %b %b want 01 0", hresp, hready_err); end
    hresetn = 1'b0;
    #1;
    total++; if (hresp !== 2'b00 || hready_err !== 1'b1) begin bad++; $display("FAIL rst_err got %b %b want 00 1", hresp, hready_err); end
    total++;
    if (haddr1 !== 0 || haddr2 !== 0 || hwdata1 !== 0 || hwdata2 !== 0 || hwrite_reg !== 0 || hwrite_reg1 !== 0) begin
      bad++; $display("FAIL rst_pipe got %h %h %h %h %b %b want 0", haddr1, haddr2, hwdata1, hwdata2, hwrite_reg, hwrite_reg1);
    end
    model_reset();
    #2;
    hresetn = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a;
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: a = 32'h7FFF_FFFF;
        1: a = 32'h8BFF_FFFF;
        2: a = 32'h8C00_0000;
        3: a = $urandom;
        default: a = 32'h8000_0000 + ($urandom % 32'h0C00_0000);
      endcase
      prdata = $urandom;
      drive(2'($urandom), a, $urandom, 1'($urandom), $urandom_range(0, 3) != 0);
      total++;
      if (valid !== f_valid() || selx !== f_selx(haddr) || hrdata !== f_hrdata()) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rnd_comb[%0d] got %b %b %h want %b %b %h", i, valid, selx, hrdata, f_valid(), f_selx(haddr), f_hrdata());
      end
      total++;
      if (hresp !== (m_err_left > 0 ? 2'b01 : 2'b00) || hready_err !== (m_err_left != 2)) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rnd_resp[%0d] got %b %b err_left=%0d", i, hresp, hready_err, m_err_left);
      end
      total++;
      if (haddr1 !== m_a1 || haddr2 !== m_a2 || hwdata1 !== m_d1 || hwdata2 !== m_d2 ||
          hwrite_reg !== m_w1 || hwrite_reg1 !== m_w2) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rnd_pipe[%0d] got %h %h %h %h want %h %h %h %h", i, haddr1, haddr2, hwdata1, hwdata2, m_a1, m_a2, m_d1, m_d2);
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_pipeline();
    test_back_to_back();
    test_hreadyin_hold();
    test_region_decode();
    test_read();
    test_reset_mid_error();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_apb_slave_if_p.md
Name: ahb_apb_slave_if_p

Overview:
Parametrised AHB-side slave interface for the AHB-to-APB bridge.
- Qualifies AHB transfers and generates `valid`.
- Registers address, write data and write direction through a two-stage pipeline for the APB controller FSM.
- Decodes the address into NUM_SEL one-hot peripheral selects.
- Returns APB read data on hrdata.
- Adds a two-cycle AHB ERROR response for transfers to unmapped addresses.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, read/write data width
NUM_SEL, 3, number of APB peripheral regions (1..8)
SEL_BASE, 32'h8000_0000, base address of region 0
REGION_LOG2, 26, log2 of region size in bytes (region i starts at SEL_BASE + i*2^REGION_LOG2)

Ports:
hclk  in  1  bus clock, rising edge
hresetn  in  1  asynchronous active-low reset
hwrite  in  1  AHB write (1) / read (0)
hreadyin  in  1  AHB bus ready
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
haddr  in  ADDR_W  AHB address
hwdata  in  DATA_W  AHB write data
prdata  in  DATA_W  APB read data from bridge
valid  out  1  qualified, mapped transfer this cycle
hwrite_reg  out  1  hwrite delayed 1 stage
hwrite_reg1  out  1  hwrite delayed 2 stages
haddr1  out  ADDR_W  haddr delayed 1 stage
haddr2  out  ADDR_W  haddr delayed 2 stages
hwdata1  out  DATA_W  hwdata delayed 1 stage
hwdata2  out  DATA_W  hwdata delayed 2 stages
selx  out  NUM_SEL  one-hot region select decoded from haddr
hrdata  out  DATA_W  read data to AHB master
hresp  out  2  00 OKAY, 01 ERROR
hready_err  out  1  slave-driven ready; 0 only in first ERROR cycle

Behaviour:
- Reset (hresetn=0, asynchronous):
  - haddr1, haddr2, hwdata1, hwdata2, hwrite_reg, hwrite_reg1 = 0.
  - Error FSM = OKAY, so hresp=00 and hready_err=1.
  - With the optional feature enabled, hrdata register = 0.
  - Deassertion takes effect at the next rising edge.
- mapped = SEL_BASE <= haddr < SEL_BASE + NUM_SEL*2^REGION_LOG2; comparison is unsigned, full ADDR_W.
- selx (combinational): bit ((haddr-SEL_BASE)>>REGION_LOG2) set when mapped, else all zero.
- active = hreadyin & htrans[1] (NONSEQ or SEQ). IDLE and BUSY are never active.
- valid (combinational) = active & mapped & FSM==OKAY.
- Pipeline: on each rising edge with hreadyin=1:
  - haddr1<=haddr, haddr2<=haddr1.
  - hwdata1<=hwdata, hwdata2<=hwdata1.
  - hwrite_reg<=hwrite, hwrite_reg1<=hwrite_reg.
  - With hreadyin=0 all pipeline registers hold. Latency is exactly 1 and 2 qualified cycles.
- Pipeline capture is independent of htrans; downstream qualifies with valid.
- Error FSM, states OKAY, ERR1, ERR2:
  - OKAY -> ERR1 when active & !mapped; otherwise stays in OKAY.
  - ERR1: hresp=01, hready_err=0, unconditionally -> ERR2.
  - ERR2: hresp=01, hready_err=1, unconditionally -> OKAY.
  - Any transfer presented during ERR1/ERR2 is ignored: valid=0 and no new error is queued.
- Boundaries:
  - Address SEL_BASE+NUM_SEL*2^REGION_LOG2-1 is mapped to the last region.
  - The next address up is unmapped.
  - Addresses below SEL_BASE are unmapped.
- Reset mid-error: the FSM returns to OKAY immediately.
- hrdata:
  - Without the optional feature: combinational pass-through of prdata.
  - With the optional feature: see below.

Optional Feature:
- Macro: AHB_SLV_RDATA_REG_EN.
- Defined: hrdata is a register loaded with prdata on every rising edge, one-cycle latency, reset to 0.
- Undefined: hrdata = prdata combinationally, no register inferred.

Test Plan:
1. Reset, then NONSEQ write (hwrite=1, hreadyin=1) with haddr=8000_0002, hwdata=28:
   - valid=1 and selx=001 that cycle.
   - Next edge: haddr1=8000_0002, hwdata1=28.
   - Following edge: haddr2=8000_0002, hwdata2=28, hwrite_reg1=1.
2. Back-to-back SEQ writes at 8000_0003/73 then 8000_0004/89, then IDLE at 8000_0005:
   - valid = 1,1,0.
   - haddr2 tracks the stream two cycles late.
3. hreadyin=0 for 3 cycles mid-stream:
   - haddr1/haddr2/hwdata1/hwdata2 hold their values.
   - valid=0 throughout.
4. Region decode at haddr=8400_0000, 8800_0010, 8BFF_FFFF, 8C00_0000:
   - selx = 010, 100, 100, 000.
   - The last address starts ERR1 (hresp=01, hready_err=0), then ERR2 (hresp=01, hready_err=1), then OKAY.
5. Read with hwrite=0 at 8000_0000 and prdata=73:
   - hrdata=73 same cycle without the macro.
   - hrdata=73 one edge later with AHB_SLV_RDATA_REG_EN.
6. Assert hresetn=0 during ERR1:
   - hresp=00, hready_err=1 and all pipeline registers = 0 immediately, without waiting for a clock edge.
